// File: rtl/ma_pkg.sv
// Shared constants and types for the multi-channel moving-average scheduler.
package ma_pkg;

    localparam int SAMPLE_W = 8;   // input sample and result width
    localparam int PROD_W   = 14;  // coefficient product and tap-sum width
    localparam int FRAC_SH  = 6;   // Q6 coefficient scaling
    localparam int COEF_A   = 21;  // about 1/3 in Q6

    // Channel tag wide enough for the largest supported channel count (16).
    localparam int TAG_W = 4;
    typedef logic [TAG_W-1:0] ch_tag_t;

    // Sign-extend a sample or coefficient to the product width.
    function automatic logic signed [PROD_W-1:0] sext(input logic signed [SAMPLE_W-1:0] v);
        return {{(PROD_W-SAMPLE_W){v[SAMPLE_W-1]}}, v};
    endfunction

endpackage

// File: rtl/ma_channel_scheduler_rr_arbiter.sv
// Round-robin arbiter: one-hot grant, search starts after the last granted channel.
module rr_arbiter
    import ma_pkg::*;
#(
    parameter int NCH = 4
) (
    input  logic           Clk,
    input  logic           Reset,
    input  logic [NCH-1:0] req,
    output logic [NCH-1:0] grant,
    output ch_tag_t        grant_idx
);

    ch_tag_t last_grant;

    // Combinational search from (last_grant + 1) mod NCH, first requester wins.
    always_comb begin
        // NOTE: every output of this block gets a default before any branch,
        // so no path leaves a value unassigned and no latch is inferred.
        grant     = '0;
        grant_idx = '0;
        for (int i = 0; i < NCH; i++) begin
            int idx;
            idx = (int'(last_grant) + 1 + i) % NCH;
            if (grant == '0 && req[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = ch_tag_t'(idx);
            end
        end
    end

    // Pointer register: moves only on a grant; reset gives channel 0 top priority.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            last_grant <= ch_tag_t'(NCH - 1);
        end else if (|grant) begin
            last_grant <= grant_idx;
        end
    end

endmodule

// File: rtl/ma_channel_scheduler.sv
// Time-multiplexed 3-tap moving average over NCH channels with a shared multiplier.
module ma_channel_scheduler
    import ma_pkg::*;
#(
    parameter int                          NCH  = 4,
    parameter logic signed [SAMPLE_W-1:0]  COEF = 8'sb00010101,
    localparam int                         CW   = $clog2(NCH)
) (
    input  logic                        Clk,
    input  logic                        Reset,
    input  logic                        enable_n,
    input  logic [NCH-1:0]              req,
    input  logic [SAMPLE_W*NCH-1:0]     X_in,
    output logic [NCH-1:0]              ack,
    output logic signed [SAMPLE_W-1:0]  Z_out,
    output logic                        Z_valid,
    output logic [CW-1:0]               Z_chan,
    output logic                        Z_primed
);

    logic [NCH-1:0]              req_gated;
    logic [NCH-1:0]              grant;
    ch_tag_t                     grant_idx;
    logic                        grant_any;
    logic signed [SAMPLE_W-1:0]  x_sel;
    logic signed [PROD_W-1:0]    prod;

    // Stage 1 registers
    logic                        v1;
    logic signed [PROD_W-1:0]    p1;
    logic [CW-1:0]               tag1;

    // Per-channel tap history (products) and fill counts
    logic signed [PROD_W-1:0]    h1 [NCH];
    logic signed [PROD_W-1:0]    h2 [NCH];
    logic [1:0]                  fill [NCH];

    logic signed [PROD_W-1:0]    sum;
    logic signed [SAMPLE_W-1:0]  z_next;

    // Gate requests so no grant is issued while disabled or in reset.
    assign req_gated = (enable_n || Reset) ? '0 : req;
    assign grant_any = |grant;
    assign ack       = grant;

    rr_arbiter #(.NCH(NCH)) u_arb (
        .Clk       (Clk),
        .Reset     (Reset),
        .req       (req_gated),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Select the granted channel's sample with a one-hot mux.
    always_comb begin
        x_sel = '0;
        for (int i = 0; i < NCH; i++) begin
            if (grant[i]) begin
                x_sel = X_in[SAMPLE_W*i +: SAMPLE_W];
            end
        end
    end

    // Shared multiplier; |COEF*X| <= 2688 fits the 14-bit product exactly.
    assign prod = sext(x_sel) * sext(COEF);

    // Stage 1: register product and tag of the granted sample.
    always_ff @(posedge Clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values and simulation matches the synthesized flops.
        if (Reset) begin
            v1   <= 1'b0;
            p1   <= '0;
            tag1 <= '0;
        end else begin
            v1 <= grant_any;
            if (grant_any) begin
                p1   <= prod;
                tag1 <= CW'(grant_idx);
            end
        end
    end

    // Tap sum; |S| <= 8064 so no overflow handling is needed.
    assign sum    = p1 + h1[tag1] + h2[tag1];
    assign z_next = SAMPLE_W'(sum >>> FRAC_SH);

    // Stage 2: produce the result and shift the channel's history on the same edge.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            Z_valid  <= 1'b0;
            Z_out    <= '0;
            Z_chan   <= '0;
            Z_primed <= 1'b0;
            // NOTE: the history file is deliberately cleared on reset so a restarted
            // stream never mixes stale taps from before the reset into its first results.
            for (int i = 0; i < NCH; i++) begin
                h1[i]   <= '0;
                h2[i]   <= '0;
                fill[i] <= '0;
            end
        end else begin
            Z_valid <= v1;
            if (v1) begin
                Z_out      <= z_next;
                Z_chan     <= tag1;
                Z_primed   <= (fill[tag1] == 2'd2);
                h2[tag1]   <= h1[tag1];
                h1[tag1]   <= p1;
                if (fill[tag1] != 2'd2) begin
                    fill[tag1] <= fill[tag1] + 2'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ma_channel_scheduler.sv
// Self-checking bench: behavioural model plus directed scenarios with literal expectations.
module tb_ma_channel_scheduler;

    localparam int NCH = 4;
    localparam int CW  = 2;

    logic                 Clk = 1'b0;
    logic                 Reset;
    logic                 enable_n;
    logic [NCH-1:0]       req;
    logic [8*NCH-1:0]     X_in;
    logic [NCH-1:0]       ack;
    logic signed [7:0]    Z_out;
    logic                 Z_valid;
    logic [CW-1:0]        Z_chan;
    logic                 Z_primed;

    ma_channel_scheduler #(.NCH(NCH)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .enable_n (enable_n),
        .req      (req),
        .X_in     (X_in),
        .ack      (ack),
        .Z_out    (Z_out),
        .Z_valid  (Z_valid),
        .Z_chan   (Z_chan),
        .Z_primed (Z_primed)
    );

    always #5 Clk = ~Clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int due;
        int z;
        int ch;
        int primed;
    } exp_t;

    typedef struct {
        int z;
        int ch;
        int primed;
    } res_t;

    exp_t exp_q[$];
    res_t res_log[$];
    int   ack_log[$];

    int   m_h1[NCH];
    int   m_h2[NCH];
    int   m_cnt[NCH];
    int   m_ptr;
    int   m_z;
    int   m_ch;
    int   cyc = 0;
    bit   started = 0;

    exp_t e;
    res_t r;
    bit   exp_valid;
    int   g;
    int   x;
    int   s;
    int   ack_idx;
    logic [NCH-1:0] exp_ack;

    // Compare process: checks every output once per cycle at the falling edge.
    always @(negedge Clk) begin
        cyc++;
        if (started) begin
            exp_valid = 0;
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                e = exp_q.pop_front();
                exp_valid = 1;
                m_z  = e.z;
                m_ch = e.ch;
            end
            check("z_valid", int'(Z_valid), int'(exp_valid));
            check("z_out", int'(Z_out), m_z);
            check("z_chan", int'(Z_chan), m_ch);
            if (exp_valid) check("z_primed", int'(Z_primed), e.primed);
            if (Z_valid) begin
                r.z = int'(Z_out); r.ch = int'(Z_chan); r.primed = int'(Z_primed);
                res_log.push_back(r);
            end

            // Expected grant: first requester after the last granted channel.
            exp_ack = '0;
            g = -1;
            if (!Reset && !enable_n) begin
                for (int k = 1; k <= NCH; k++) begin
                    if (g < 0 && req[(m_ptr + k) % NCH]) g = (m_ptr + k) % NCH;
                end
            end
            if (g >= 0) exp_ack[g] = 1'b1;
            check("ack", int'(ack), int'(exp_ack));

            ack_idx = -1;
            for (int k = 0; k < NCH; k++) if (ack[k]) ack_idx = k;
            if (ack_idx >= 0) ack_log.push_back(ack_idx);

            if (g >= 0) begin
                x = int'($signed(X_in[8*g +: 8]));
                s = 21 * (x + m_h1[g] + m_h2[g]);
                e.due    = cyc + 2;
                e.z      = s >>> 6;
                e.ch     = g;
                e.primed = (m_cnt[g] >= 2) ? 1 : 0;
                exp_q.push_back(e);
                m_h2[g] = m_h1[g];
                m_h1[g] = x;
                if (m_cnt[g] < 2) m_cnt[g]++;
                m_ptr = g;
            end
        end
        if (Reset) begin
            started = 1;
            exp_q.delete();
            for (int k = 0; k < NCH; k++) begin
                m_h1[k] = 0; m_h2[k] = 0; m_cnt[k] = 0;
            end
            m_ptr = NCH - 1;
            m_z   = 0;
            m_ch  = 0;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic set_x(input int ch, input int v);
        X_in[8*ch +: 8] = 8'(v);
    endtask

    task automatic clear_logs();
        res_log.delete();
        ack_log.delete();
    endtask

    task automatic check_res(input string name, input int idx, input int z, input int ch, input int primed);
        check({name, "_present"}, int'(res_log.size() > idx), 1);
        if (res_log.size() > idx) begin
            check({name, "_z"}, res_log[idx].z, z);
            check({name, "_chan"}, res_log[idx].ch, ch);
            check({name, "_primed"}, res_log[idx].primed, primed);
        end
    endtask

    task automatic check_acks(input string name, input int idx, input int ch);
        check({name, "_present"}, int'(ack_log.size() > idx), 1);
        if (ack_log.size() > idx) check(name, ack_log[idx], ch);
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        Reset = 1'b1; enable_n = 1'b0; req = '0; X_in = '0;
        step(2);
        Reset = 1'b0;
        check("rst_z_out", int'(Z_out), 0);
        check("rst_z_valid", int'(Z_valid), 0);
        check("rst_z_chan", int'(Z_chan), 0);
        check("rst_z_primed", int'(Z_primed), 0);
        check("rst_ack", int'(ack), 0);

        // ch0 sends 64 three times back-to-back
        clear_logs();
        set_x(0, 64); req = 4'b0001;
        step(3);
        req = '0;
        step(4);
        check("ch0_n", res_log.size(), 3);
        check_res("ch0_a", 0, 21, 0, 0);
        check_res("ch0_b", 1, 42, 0, 0);
        check_res("ch0_c", 2, 63, 0, 1);
        check("ch0_acks", ack_log.size(), 3);

        // ch1 sends -128 three times
        clear_logs();
        set_x(1, -128); req = 4'b0010;
        step(3);
        req = '0;
        step(4);
        check_res("ch1_a", 0, -42, 1, 0);
        check_res("ch1_b", 1, -84, 1, 0);
        check_res("ch1_c", 2, -126, 1, 1);

        // All four channels requesting from reset: round-robin interleave
        Reset = 1'b1;
        set_x(0, 64); set_x(1, 10); set_x(2, -64); set_x(3, -10);
        req = 4'b1111;
        step(2);
        Reset = 1'b0;
        clear_logs();
        step(8);
        req = '0;
        step(4);
        for (int i = 0; i < 8; i++) check_acks("rr_ack", i, i % 4);
        check_res("rr_0", 0, 21, 0, 0);
        check_res("rr_1", 1, 3, 1, 0);
        check_res("rr_2", 2, -21, 2, 0);
        check_res("rr_3", 3, -4, 3, 0);
        check_res("rr_4", 4, 42, 0, 0);
        check_res("rr_5", 5, 6, 1, 0);
        check_res("rr_6", 6, -42, 2, 0);
        check_res("rr_7", 7, -7, 3, 0);

        // enable_n raised right after a grant; resume from the next channel
        clear_logs();
        req = 4'b0011;
        step(1);
        req = 4'b0010; enable_n = 1'b1;
        step(4);
        check("en_hold_acks", ack_log.size(), 1);
        enable_n = 1'b0;
        step(1);
        req = '0;
        step(4);
        check_acks("en_ack0", 0, 0);
        check_acks("en_ack1", 1, 1);
        check_res("en_ch0", 0, 63, 0, 1);
        check_res("en_ch1", 1, 9, 1, 1);

        // Reset while both pipeline stages are busy
        clear_logs();
        set_x(0, 64); req = 4'b0001;
        step(2);
        Reset = 1'b1; req = '0;
        step(1);
        Reset = 1'b0;
        check("mid_rst_z_out", int'(Z_out), 0);
        check("mid_rst_z_valid", int'(Z_valid), 0);
        check("mid_rst_z_chan", int'(Z_chan), 0);
        step(4);
        check("mid_rst_n", res_log.size(), 1);
        check_res("mid_rst_pre", 0, 63, 0, 1);
        clear_logs();
        req = 4'b0001;
        step(1);
        req = '0;
        step(4);
        check("post_rst_n", res_log.size(), 1);
        check_res("post_rst", 0, 21, 0, 0);

        // Boundary: max positive sample on ch2
        clear_logs();
        set_x(2, 127); req = 4'b0100;
        step(3);
        req = '0;
        step(4);
        check_res("max_a", 0, 41, 2, 0);
        check_res("max_b", 1, 83, 2, 0);
        check_res("max_c", 2, 125, 2, 1);
        check("model_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ma_channel_scheduler.md
Name: ma_channel_scheduler

Overview:
- Time-multiplexes one 3-tap moving-average datapath, Z = (A*x[n] + A*x[n-1] + A*x[n-2]) >> 6, across NCH independent sample channels.
- Arbitrates requesting channels round-robin and stores per-channel tap history.
- Produces a tagged result stream through a 2-stage pipeline with a single shared multiplier.
- Sits between the per-channel sample sources and the downstream result consumer.

Parameters:
- NCH, 4, number of channels (2..16).
- COEF, 8'sb00010101 (21, about 1/3 in Q6), signed tap coefficient.
- CW, $clog2(NCH), localparam, channel-tag width.

Ports:
- Clk  in  1  clock. Everything is sampled on the rising edge.
- Reset  in  1  synchronous reset, active-high.
- enable_n  in  1  active-low run enable. Grants are issued only while it is low.
- req  in  NCH  per-channel sample request, one bit per channel.
- X_in  in  8*NCH  signed samples, flattened. Channel i occupies [8i+7:8i].
- ack  out  NCH  one-hot grant. The sample is consumed in the cycle ack[i] is high.
- Z_out  out  8  signed filtered result.
- Z_valid  out  1  Z_out, Z_chan and Z_primed are valid this cycle.
- Z_chan  out  CW  channel tag of Z_out.
- Z_primed  out  1  the channel had at least 2 prior samples, so all taps are real data.

Behaviour:
- Reset (synchronous, Reset=1 at the edge):
  - Z_out=0, Z_valid=0, Z_chan=0, Z_primed=0, ack=0.
  - All history registers = 0 and all fill counts = 0.
  - Pipeline valids cleared; round-robin pointer set so channel 0 has top priority.
  - Reset mid-operation discards in-flight samples; no Z_valid is produced for them.
- Source handshake: a source holds req[i]=1 and X_in[i] stable until it sees ack[i]=1. It may deassert req[i] only after the ack cycle.
- ack is combinational from req, the pointer and enable_n:
  - ack=0 while enable_n=1 or Reset=1.
  - At most one bit is set.
- Arbitration:
  - Search starts at channel (last_grant+1) mod NCH and wraps.
  - The first channel with req set wins.
  - last_grant updates only on a grant.
  - A single requester is granted every cycle; back-to-back grants to the same channel are allowed.
- Pipeline, grant in cycle c:
  - Stage 1, registered at the end of c: P = COEF*X (14-bit signed), tag, v1=1.
  - Stage 2, registered at the end of c+1:
    - S = P + H1[tag] + H2[tag], 14-bit signed.
    - Z_out = S[13:6] (arithmetic floor), Z_valid=1, Z_chan=tag.
    - Z_primed = (fill[tag]==2).
    - Same edge updates: H2[tag] <= H1[tag], H1[tag] <= P, fill[tag] saturates at 2.
  - Z_valid is seen in cycle c+2. Latency is 2 cycles and throughput is 1 result per cycle.
- Same-channel back-to-back: stage 2 of sample k+1 reads the history written at the end of stage 2 of sample k. No forwarding is needed and there is no hazard.
- Width: |S| <= 3*128*21 = 8064 < 8192, so there is no overflow or saturation logic.
- Z_valid is a one-cycle pulse per result. There is no downstream backpressure; the consumer must accept every result.
- enable_n=1 mid-stream: no new grants. In-flight samples still complete; history and pointer are held.
- Idle cycles (no grant) leave Z_out and Z_chan at their last values with Z_valid=0.

Decomposition:
- Package ma_pkg holds:
  - COEF_A = 21 and the widths SAMPLE_W=8, PROD_W=14, FRAC_SH=6.
  - The channel tag typedef.
- Sub-module rr_arbiter (NCH requests -> one-hot grant, pointer update on grant). The remaining datapath and history RAM stay flat in ma_channel_scheduler.

Test Plan:
- Reset, then ch0 sends 64 three times back-to-back -> ack[0] each cycle; Z_out=21, 42, 63 on 3 consecutive cycles starting 2 cycles after the first ack; Z_chan=0; Z_primed=0, 0, 1.
- ch1 sends -128 three times -> Z_out = -42, -84, -126 (floor; S=-8064); Z_chan=1.
- All NCH=4 reqs held high from reset -> ack order 0, 1, 2, 3, 0, ...; Z_chan follows the same order 2 cycles later; each channel's history is independent (interleave ch0=64, ch2=-64 -> 21, -21, 42, -42, ...).
- enable_n raised the cycle after a grant -> that result still appears 2 cycles after its ack, then no ack while enable_n=1. Lowering enable_n resumes from the next channel after last_grant, and history is preserved (next ch0=64 gives 63).
- Reset asserted while stage 1 and stage 2 are valid -> no Z_valid afterwards and all outputs 0. The next ch0=64 gives Z_out=21 with Z_primed=0.
- Boundary: max positive 127 three times -> 41, 83, 125 (S=8001); no overflow anywhere.
